// File: rtl/muldiv_pkg.sv
// Shared types for the multi-cycle multiply/divide sequencer: FSM states,
// operation codes and the control encodings for the shared adder/subtractor.
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_MUL  = 1'b0,
    OP_DIVU = 1'b1
  } op_e;

  typedef struct packed {
    logic ctl1;
    logic ctl0;
  } addsub_ctl_t;

  localparam addsub_ctl_t ADDSUB_ADD = '{ctl1: 1'b0, ctl0: 1'b0};
  localparam addsub_ctl_t ADDSUB_SUB = '{ctl1: 1'b0, ctl0: 1'b1};

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response channels between the issue stage (master) and the
// multiply/divide sequencer (slave), plus the in-flight abort.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             kill;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_lo;
  logic [WIDTH-1:0] resp_hi;
  logic             resp_dbz;

  modport master (
    output req_valid, req_op, req_a, req_b, kill, resp_ready,
    input  req_ready, resp_valid, resp_lo, resp_hi, resp_dbz
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, kill, resp_ready,
    output req_ready, resp_valid, resp_lo, resp_hi, resp_dbz
  );
endinterface

// File: rtl/muldiv_iter_counter.sv
// Iteration counter for the sequencer: synchronous clear, count enable and a
// terminal-count flag raised during the last of ITERS iterations.
module muldiv_iter_counter #(
  parameter int ITERS = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int CW = $clog2(ITERS) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CW'(ITERS - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned multiply (shift-add) and restoring divide engine that
// borrows the shared 32-bit adder/subtractor one iteration per cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic                clk,
  input  logic                reset_n,
  muldiv_sequencer_if.slave   bus,
  output logic [WIDTH-1:0]    adder_a,
  output logic [WIDTH-1:0]    adder_b,
  output logic                adder_ctl0,
  output logic                adder_ctl1,
  input  logic [WIDTH-1:0]    adder_out,
  input  logic                adder_cout
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d;     // MUL: product high half; DIVU: remainder
  logic [WIDTH-1:0] lo_q, lo_d;     // MUL: multiplier/product low; DIVU: dividend/quotient
  logic [WIDTH-1:0] opnd_q, opnd_d; // MUL: multiplicand; DIVU: divisor
  logic             dbz_q, dbz_d;

  logic             cnt_clear, cnt_en, cnt_tc;
  addsub_ctl_t      adder_ctl;
  logic [WIDTH-1:0] div_shift;
  logic             quot_bit;

  muldiv_iter_counter #(.ITERS(ITERS)) u_iter_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (cnt_clear),
    .en_i    (cnt_en),
    .tc_o    (cnt_tc)
  );

  // The remainder's top bit is the 33rd bit of the shifted partial remainder:
  // when set, the subtraction always fits even though the adder reports a borrow.
  assign div_shift = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign quot_bit  = hi_q[WIDTH-1] | adder_cout;

  always_comb begin
    adder_a   = '0;
    adder_b   = '0;
    adder_ctl = ADDSUB_ADD;
    if (state_q == ST_RUN) begin
      if (op_q == OP_MUL) begin
        adder_a = hi_q;
        adder_b = lo_q[0] ? opnd_q : '0;
      end else begin
        adder_a   = div_shift;
        adder_b   = opnd_q;
        adder_ctl = ADDSUB_SUB;
      end
    end
  end

  assign adder_ctl0 = adder_ctl.ctl0;
  assign adder_ctl1 = adder_ctl.ctl1;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    dbz_d     = dbz_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // kill is ignored here: it only ever aborts an op already in flight
        if (bus.req_valid) begin
          op_d      = op_e'(bus.req_op);
          cnt_clear = 1'b1;
          dbz_d     = 1'b0;
          hi_d      = '0;
          state_d   = ST_RUN;
          if (op_e'(bus.req_op) == OP_MUL) begin
            opnd_d = bus.req_a;
            lo_d   = bus.req_b;
          end else begin
            opnd_d = bus.req_b;
            lo_d   = bus.req_a;
            if (bus.req_b == '0) begin
              lo_d    = '1;
              hi_d    = bus.req_a;
              dbz_d   = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (op_q == OP_MUL) begin
          {hi_d, lo_d} = {adder_cout, adder_out, lo_q[WIDTH-1:1]};
        end else begin
          hi_d = quot_bit ? adder_out : div_shift;
          lo_d = {lo_q[WIDTH-2:0], quot_bit};
        end
        if (cnt_tc) begin
          state_d = ST_DONE;
        end
        if (bus.kill) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (bus.resp_ready || bus.kill) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_DONE);
  assign bus.resp_lo    = lo_q;
  assign bus.resp_hi    = hi_q;
  assign bus.resp_dbz   = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed corner cases plus random MUL/DIVU ops
// checked against plain-arithmetic expectations; the shared adder is modelled here.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic clk;
  logic reset_n;

  logic [W-1:0] adder_a, adder_b, adder_out;
  logic         adder_ctl0, adder_ctl1, adder_cout;
  logic [W:0]   add_sum;

  int vectors;
  int miscompares;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W), .ITERS(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_ctl0 (adder_ctl0),
    .adder_ctl1 (adder_ctl1),
    .adder_out  (adder_out),
    .adder_cout (adder_cout)
  );

  // Shared AdderSubtractor: SUB inverts B with carry-in 1; cout=1 means no borrow.
  assign add_sum    = {1'b0, adder_a} + {1'b0, (adder_ctl0 ? ~adder_b : adder_b)}
                    + {{W{1'b0}}, adder_ctl0};
  assign adder_out  = add_sum[W-1:0];
  assign adder_cout = add_sum[W];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one op and collect its response; expectations come from * / %.
  task automatic do_op(input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input bit kill_with_req, input bit kill_on_take,
                       input string tag);
    logic [63:0]  prod;
    logic [W-1:0] exp_lo, exp_hi;
    bit           exp_dbz;
    int           exp_lat;
    int           n;

    if (op == 1'b0) begin
      prod    = 64'(a) * 64'(b);
      exp_lo  = prod[W-1:0];
      exp_hi  = prod[63:W];
      exp_dbz = 1'b0;
      exp_lat = W + 1;
    end else if (b == '0) begin
      exp_lo  = '1;
      exp_hi  = a;
      exp_dbz = 1'b1;
      exp_lat = 1;
    end else begin
      exp_lo  = a / b;
      exp_hi  = a % b;
      exp_dbz = 1'b0;
      exp_lat = W + 1;
    end

    check({tag, ".ready_before"}, bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.kill      = kill_with_req;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.kill      = 1'b0;
    n = 1;
    if (exp_lat > 1) begin
      check({tag, ".run_ctl0"}, adder_ctl0, op);
      check({tag, ".run_ctl1"}, adder_ctl1, 0);
    end
    while (!bus.resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, n, exp_lat);
    check({tag, ".lo"}, bus.resp_lo, exp_lo);
    check({tag, ".hi"}, bus.resp_hi, exp_hi);
    check({tag, ".dbz"}, bus.resp_dbz, exp_dbz);
    check({tag, ".adder_quiet"}, {adder_a, adder_b}, 0);
    check({tag, ".ctl_quiet"}, {adder_ctl1, adder_ctl0}, 0);
    check({tag, ".ready_busy"}, bus.req_ready, 0);

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, bus.resp_valid, 1);
      check({tag, ".hold_result"}, {bus.resp_hi, bus.resp_lo}, {exp_hi, exp_lo});
      check({tag, ".hold_ready"}, bus.req_ready, 0);
    end

    bus.resp_ready = 1'b1;
    bus.kill       = kill_on_take;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.kill       = 1'b0;
    check({tag, ".after_take"}, {bus.resp_valid, bus.req_ready}, 2'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit               stale;
    bit               r_op;
    logic [W-1:0]     r_a, r_b;
    int               sel;

    vectors        = 0;
    miscompares    = 0;
    reset_n        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.kill       = 1'b0;
    bus.resp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("reset.req_ready", bus.req_ready, 1);
    check("reset.resp_valid", bus.resp_valid, 0);
    check("reset.result", {bus.resp_hi, bus.resp_lo}, 0);
    check("reset.dbz", bus.resp_dbz, 0);
    check("reset.adder", {adder_a, adder_b, adder_ctl1, adder_ctl0}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    do_op(1'b0, 32'h0000_0007, 32'h0000_0006, 0, 1'b0, 1'b0, "mul7x6");
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, "mul_max");
    do_op(1'b1, 32'd100, 32'd7, 0, 1'b0, 1'b0, "div100_7");
    do_op(1'b1, 32'h8000_0001, 32'd2, 0, 1'b0, 1'b0, "div_top");
    do_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 0, 1'b0, 1'b0, "div_bigdiv");
    do_op(1'b1, 32'd5, 32'd0, 0, 1'b0, 1'b0, "div_by0");
    do_op(1'b0, 32'h1234_5678, 32'h0000_0010, 10, 1'b0, 1'b0, "hold10");
    do_op(1'b0, 32'd9, 32'd9, 0, 1'b1, 1'b0, "kill_idle_req");
    do_op(1'b1, 32'd77, 32'd5, 2, 1'b0, 1'b1, "kill_with_take");

    // Abort at RUN cycle 15; nothing from that op may ever surface.
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b0;
    bus.req_a     = 32'hDEAD_BEEF;
    bus.req_b     = 32'h0BAD_F00D;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (14) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_run.req_ready", bus.req_ready, 1);
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      stale |= bus.resp_valid;
      @(negedge clk);
    end
    check("kill_run.no_stale", stale, 0);
    do_op(1'b0, 32'd3, 32'd4, 0, 1'b0, 1'b0, "mul3x4_after_kill");

    // Asynchronous reset in the middle of a divide.
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b1;
    bus.req_a     = 32'h7654_3210;
    bus.req_b     = 32'd13;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_mid.req_ready", bus.req_ready, 1);
    check("rst_mid.resp_valid", bus.resp_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_mid.idle_after", {bus.resp_valid, bus.req_ready}, 2'b01);
    do_op(1'b1, 32'd1000, 32'd33, 0, 1'b0, 1'b0, "div_after_rst");

    for (int i = 0; i < 24; i++) begin
      r_op = 1'($urandom_range(0, 1));
      r_a  = $urandom;
      sel  = int'($urandom_range(0, 7));
      if (sel == 0)      r_b = '0;
      else if (sel == 1) r_b = $urandom_range(1, 15);
      else               r_b = $urandom;
      do_op(r_op, r_a, r_b, int'($urandom_range(0, 3)), 1'b0, 1'b0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
